// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Arbitrates the single-port data memory between the CPU memory
//               stage and a debug/loader port. The CPU wins by default; a debug
//               request blocked for MAX_WAIT consecutive cycles is granted a
//               slot, and the CPU is stalled for that one cycle.
// Ports       :
//   clk_i, reset_i          clock (rising edge), async active-high reset
//   cpu_en_i/wr_i/addr_i/   CPU access request (held while stalled)
//   cpu_data_i
//   cpu_data_o              CPU read data (holds last CPU read value)
//   cpu_stall_o             CPU access not served this cycle
//   dbg_req_i/wr_i/addr_i/  debug request, held until dbg_ack_o
//   dbg_data_i
//   dbg_ack_o               one-cycle completion pulse
//   dbg_data_o              debug read data while dbg_ack_o, else 0
//   mem_en_o/wr_o/addr_o/   to data memory
//   mem_data_o
//   mem_data_i              from data memory (1-cycle registered read)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_en_i,
    input  logic              cpu_wr_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_wr_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_data_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic              mem_en_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    localparam int          c_CNT_W = $clog2(MAX_WAIT + 1);
    localparam [c_CNT_W-1:0] c_MAX  = c_CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_WAIT = 2'd1,
        D_ACK  = 2'd2
    } dbg_state_t;

    dbg_state_t          r_state;
    dbg_state_t          w_state_nxt;
    logic [c_CNT_W-1:0]  r_wait_cnt;
    logic [c_CNT_W-1:0]  w_wait_cnt_nxt;
    logic                r_dbg_wr;       // direction of the granted debug access
    logic                r_cpu_rd_prev;  // previous cycle was a served CPU read
    logic [DATA_W-1:0]   r_cpu_hold;     // last CPU read value
    logic                w_grant;
    logic                w_cpu_rd;

    // Debug wins only when the CPU is idle or the debug port has starved long
    // enough; never during the ack cycle, so back-to-back accesses are >=2 apart.
    assign w_grant  = dbg_req_i && (r_state != D_ACK) &&
                      (!cpu_en_i || (r_wait_cnt == c_MAX));
    assign w_cpu_rd = cpu_en_i && !cpu_wr_i && !w_grant;

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            D_IDLE, D_WAIT: begin
                if (w_grant) begin
                    w_state_nxt    = D_ACK;
                    w_wait_cnt_nxt = '0;
                end else if (dbg_req_i) begin
                    w_state_nxt    = D_WAIT;
                    w_wait_cnt_nxt = (r_wait_cnt == c_MAX) ? r_wait_cnt
                                                           : r_wait_cnt + 1'b1;
                end else begin
                    w_state_nxt    = D_IDLE;
                    w_wait_cnt_nxt = '0;
                end
            end
            D_ACK: begin
                w_state_nxt    = D_IDLE;
                w_wait_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt    = D_IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // Memory mux and stall
    always_comb begin
        mem_en_o    = 1'b0;
        mem_wr_o    = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        cpu_stall_o = w_grant && cpu_en_i;
        if (w_grant) begin
            mem_en_o   = 1'b1;
            mem_wr_o   = dbg_wr_i;
            mem_addr_o = dbg_addr_i;
            mem_data_o = dbg_data_i;
        end else if (cpu_en_i) begin
            mem_en_o   = 1'b1;
            mem_wr_o   = cpu_wr_i;
            mem_addr_o = cpu_addr_i;
            mem_data_o = cpu_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= D_IDLE;
            r_wait_cnt    <= '0;
            r_dbg_wr      <= 1'b0;
            r_cpu_rd_prev <= 1'b0;
            r_cpu_hold    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            if (w_grant) begin
                r_dbg_wr <= dbg_wr_i;
            end
            r_cpu_rd_prev <= w_cpu_rd;
            if (r_cpu_rd_prev) begin
                r_cpu_hold <= mem_data_i;
            end
        end
    end

    // The memory read port is shared, so CPU data is only taken from it in the
    // cycle after a CPU read; otherwise the last CPU value is replayed.
    assign cpu_data_o = r_cpu_rd_prev ? mem_data_i : r_cpu_hold;
    assign dbg_ack_o  = (r_state == D_ACK);
    assign dbg_data_o = ((r_state == D_ACK) && !r_dbg_wr) ? mem_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a simple
//               registered-read memory model attached to the mem_* port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              cpu_en_i, cpu_wr_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_data_i;
    logic [DATA_W-1:0] cpu_data_o;
    logic              cpu_stall_o;
    logic              dbg_req_i, dbg_wr_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_data_i;
    logic              dbg_ack_o;
    logic [DATA_W-1:0] dbg_data_o;
    logic              mem_en_o, mem_wr_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cpu_en_i(cpu_en_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .dbg_req_i(dbg_req_i), .dbg_wr_i(dbg_wr_i), .dbg_addr_i(dbg_addr_i),
        .dbg_data_i(dbg_data_i), .dbg_ack_o(dbg_ack_o), .dbg_data_o(dbg_data_o),
        .mem_en_o(mem_en_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Data memory model: registered read, read-before-write, contents preloaded
    // on the first clock edge.
    logic [DATA_W-1:0] tb_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] tb_rdata = '0;
    bit                tb_loaded = 1'b0;
    always @(posedge clk_i) begin
        if (!tb_loaded) begin
            tb_mem[11'h010] <= 32'hDEADBEEF;
            tb_mem[11'h020] <= 32'hA5A5A5A5;
            tb_mem[11'h030] <= 32'h00000000;
            tb_mem[11'h7FF] <= 32'h00000000;
            tb_loaded       <= 1'b1;
        end else if (mem_en_o) begin
            if (mem_wr_o) tb_mem[mem_addr_o] <= mem_data_o;
            else          tb_rdata           <= tb_mem[mem_addr_o];
        end
    end
    assign mem_data_i = tb_rdata;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Every task starts and ends 1 time unit after a rising edge.

    task automatic test_reset();
        reset_i = 1'b1;
        cpu_en_i = 0; cpu_wr_i = 0; cpu_addr_i = '0; cpu_data_i = '0;
        dbg_req_i = 0; dbg_wr_i = 0; dbg_addr_i = '0; dbg_data_i = '0;
        #1;
        n_checks++; if (dbg_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", dbg_ack_o); end
        n_checks++; if (dbg_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_dbg_data: got %h expected 0", dbg_data_o); end
        n_checks++; if (cpu_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_cpu_data: got %h expected 0", cpu_data_o); end
        n_checks++; if (mem_en_o !== 1'b0 || cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en_stall: got %b/%b expected 0/0", mem_en_o, cpu_stall_o); end
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic test_cpu_only();
        cpu_en_i = 1; cpu_wr_i = 0; cpu_addr_i = 11'h010;
        #1;
        n_checks++; if (mem_en_o !== 1'b1 || mem_wr_o !== 1'b0 || mem_addr_o !== 11'h010) begin n_fail++; $display("FAIL cpu_mem_drive: got en=%b wr=%b addr=%h expected 1 0 010", mem_en_o, mem_wr_o, mem_addr_o); end
        n_checks++; if (cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL cpu_stall_c0: got %b expected 0", cpu_stall_o); end
        @(posedge clk_i); #1;
        cpu_en_i = 0;
        #1;
        n_checks++; if (cpu_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cpu_read_data: got %h expected deadbeef", cpu_data_o); end
        n_checks++; if (mem_en_o !== 1'b0 || mem_addr_o !== 11'h0) begin n_fail++; $display("FAIL idle_bus: got en=%b addr=%h expected 0 000", mem_en_o, mem_addr_o); end
        @(posedge clk_i); #1;
        n_checks++; if (cpu_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cpu_read_hold: got %h expected deadbeef", cpu_data_o); end
    endtask

    task automatic test_debug_idle();
        dbg_req_i = 1; dbg_wr_i = 1; dbg_addr_i = 11'h7FF; dbg_data_i = 32'h12345678;
        #1;
        n_checks++; if (mem_wr_o !== 1'b1 || mem_addr_o !== 11'h7FF || mem_data_o !== 32'h12345678) begin n_fail++; $display("FAIL dbg_write_drive: got wr=%b addr=%h data=%h expected 1 7ff 12345678", mem_wr_o, mem_addr_o, mem_data_o); end
        n_checks++; if (dbg_ack_o !== 1'b0) begin n_fail++; $display("FAIL dbg_write_early_ack: got %b expected 0", dbg_ack_o); end
        @(posedge clk_i); #1;
        dbg_req_i = 0;
        #1;
        n_checks++; if (dbg_ack_o !== 1'b1 || dbg_data_o !== 32'h0) begin n_fail++; $display("FAIL dbg_write_ack: got ack=%b data=%h expected 1 00000000", dbg_ack_o, dbg_data_o); end
        @(posedge clk_i); #1;
        dbg_req_i = 1; dbg_wr_i = 0; dbg_addr_i = 11'h7FF; dbg_data_i = '0;
        #1;
        n_checks++; if (dbg_ack_o !== 1'b0 || mem_en_o !== 1'b1 || mem_wr_o !== 1'b0) begin n_fail++; $display("FAIL dbg_read_drive: got ack=%b en=%b wr=%b expected 0 1 0", dbg_ack_o, mem_en_o, mem_wr_o); end
        @(posedge clk_i); #1;
        dbg_req_i = 0;
        #1;
        n_checks++; if (dbg_ack_o !== 1'b1 || dbg_data_o !== 32'h12345678) begin n_fail++; $display("FAIL dbg_readback: got ack=%b data=%h expected 1 12345678", dbg_ack_o, dbg_data_o); end
        n_checks++; if (cpu_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cpu_data_isolated: got %h expected deadbeef", cpu_data_o); end
        @(posedge clk_i); #1;
        n_checks++; if (dbg_ack_o !== 1'b0 || dbg_data_o !== 32'h0) begin n_fail++; $display("FAIL dbg_ack_single: got ack=%b data=%h expected 0 00000000", dbg_ack_o, dbg_data_o); end
    endtask

    task automatic test_starvation();
        cpu_en_i = 1; cpu_wr_i = 0; cpu_addr_i = 11'h010;
        dbg_req_i = 1; dbg_wr_i = 0; dbg_addr_i = 11'h020;
        for (int c = 0; c <= MAX_WAIT; c++) begin
            #1;
            n_checks++; if (cpu_stall_o !== (c == MAX_WAIT)) begin n_fail++; $display("FAIL starve_stall_c%0d: got %b expected %b", c, cpu_stall_o, (c == MAX_WAIT)); end
            n_checks++; if (mem_addr_o !== ((c == MAX_WAIT) ? 11'h020 : 11'h010) || dbg_ack_o !== 1'b0) begin n_fail++; $display("FAIL starve_owner_c%0d: got addr=%h ack=%b", c, mem_addr_o, dbg_ack_o); end
            @(posedge clk_i); #1;
        end
        dbg_req_i = 0;
        #1;
        n_checks++; if (dbg_ack_o !== 1'b1 || dbg_data_o !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL starve_ack: got ack=%b data=%h expected 1 a5a5a5a5", dbg_ack_o, dbg_data_o); end
        n_checks++; if (cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL starve_stall_after: got %b expected 0", cpu_stall_o); end
        n_checks++; if (cpu_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL starve_cpu_hold: got %h expected deadbeef", cpu_data_o); end
        @(posedge clk_i); #1;
        cpu_en_i = 0;
        #1;
        n_checks++; if (dbg_ack_o !== 1'b0 || cpu_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL starve_end: got ack=%b cpu=%h expected 0 deadbeef", dbg_ack_o, cpu_data_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_back_to_back();
        dbg_req_i = 1; dbg_wr_i = 0; dbg_addr_i = 11'h020;
        #1;
        n_checks++; if (mem_en_o !== 1'b1 || mem_addr_o !== 11'h020) begin n_fail++; $display("FAIL b2b_grant1: got en=%b addr=%h expected 1 020", mem_en_o, mem_addr_o); end
        @(posedge clk_i); #1; #1;
        n_checks++; if (dbg_ack_o !== 1'b1 || mem_en_o !== 1'b0) begin n_fail++; $display("FAIL b2b_no_regrant_in_ack: got ack=%b en=%b expected 1 0", dbg_ack_o, mem_en_o); end
        @(posedge clk_i); #1; #1;
        n_checks++; if (dbg_ack_o !== 1'b0 || mem_en_o !== 1'b1) begin n_fail++; $display("FAIL b2b_grant2: got ack=%b en=%b expected 0 1", dbg_ack_o, mem_en_o); end
        @(posedge clk_i); #1;
        dbg_req_i = 0;
        #1;
        n_checks++; if (dbg_ack_o !== 1'b1 || dbg_data_o !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_ack2: got ack=%b data=%h expected 1 a5a5a5a5", dbg_ack_o, dbg_data_o); end
        @(posedge clk_i); #1; #1;
        n_checks++; if (dbg_ack_o !== 1'b0 || mem_en_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got ack=%b en=%b expected 0 0", dbg_ack_o, mem_en_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_withdraw();
        cpu_en_i = 1; cpu_wr_i = 0; cpu_addr_i = 11'h010;
        dbg_req_i = 1; dbg_wr_i = 1; dbg_addr_i = 11'h030; dbg_data_i = 32'h00000055;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (cpu_stall_o !== 1'b0 || mem_wr_o !== 1'b0 || mem_addr_o !== 11'h010) begin n_fail++; $display("FAIL withdraw_blocked_c%0d: got stall=%b wr=%b addr=%h", c, cpu_stall_o, mem_wr_o, mem_addr_o); end
            @(posedge clk_i); #1;
        end
        dbg_req_i = 0;
        #1;
        n_checks++; if (dbg_ack_o !== 1'b0 || mem_wr_o !== 1'b0) begin n_fail++; $display("FAIL withdraw_drop: got ack=%b wr=%b expected 0 0", dbg_ack_o, mem_wr_o); end
        @(posedge clk_i); #1; #1;
        n_checks++; if (dbg_ack_o !== 1'b0 || tb_mem[11'h030] !== 32'h0) begin n_fail++; $display("FAIL withdraw_no_access: got ack=%b mem30=%h expected 0 00000000", dbg_ack_o, tb_mem[11'h030]); end
        // A fresh request must again wait the full MAX_WAIT cycles.
        dbg_req_i = 1; dbg_wr_i = 0; dbg_addr_i = 11'h020; dbg_data_i = '0;
        for (int c = 0; c <= MAX_WAIT; c++) begin
            #1;
            n_checks++; if (cpu_stall_o !== (c == MAX_WAIT)) begin n_fail++; $display("FAIL withdraw_recount_c%0d: got %b expected %b", c, cpu_stall_o, (c == MAX_WAIT)); end
            @(posedge clk_i); #1;
        end
        dbg_req_i = 0; cpu_en_i = 0;
        #1;
        n_checks++; if (dbg_ack_o !== 1'b1 || dbg_data_o !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL withdraw_reack: got ack=%b data=%h expected 1 a5a5a5a5", dbg_ack_o, dbg_data_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_in_ack();
        dbg_req_i = 1; dbg_wr_i = 0; dbg_addr_i = 11'h020;
        #1;
        n_checks++; if (mem_en_o !== 1'b1) begin n_fail++; $display("FAIL rst_ack_grant: got %b expected 1", mem_en_o); end
        @(posedge clk_i); #1;
        dbg_req_i = 0;
        #1;
        n_checks++; if (dbg_ack_o !== 1'b1) begin n_fail++; $display("FAIL rst_ack_pre: got %b expected 1", dbg_ack_o); end
        reset_i = 1'b1;
        #1;
        n_checks++; if (dbg_ack_o !== 1'b0 || dbg_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_ack_async: got ack=%b data=%h expected 0 00000000", dbg_ack_o, dbg_data_o); end
        n_checks++; if (cpu_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_ack_cpu_data: got %h expected 0", cpu_data_o); end
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        #1;
        n_checks++; if (dbg_ack_o !== 1'b0 || mem_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_release: got ack=%b en=%b expected 0 0", dbg_ack_o, mem_en_o); end
        dbg_req_i = 1;
        #1;
        n_checks++; if (mem_en_o !== 1'b1 || mem_addr_o !== 11'h020) begin n_fail++; $display("FAIL rst_idle_regrant: got en=%b addr=%h expected 1 020", mem_en_o, mem_addr_o); end
        @(posedge clk_i); #1;
        dbg_req_i = 0;
        #1;
        n_checks++; if (dbg_ack_o !== 1'b1 || dbg_data_o !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rst_reissue_ack: got ack=%b data=%h expected 1 a5a5a5a5", dbg_ack_o, dbg_data_o); end
        @(posedge clk_i); #1;
    endtask

    initial begin
        test_reset();
        test_cpu_only();
        test_debug_idle();
        test_starvation();
        test_back_to_back();
        test_withdraw();
        test_reset_in_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
